// File: rtl/mem_order_checker.sv
// Scans COUNT consecutive memory words and checks that every adjacent pair is ordered.
// Reports pass/fail, a read timeout, and the index of the first out-of-order pair.
module mem_order_checker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned STRIDE     = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic                  desc,
  input  logic                  is_signed,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  fail_index
);

  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CMP, S_FIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  desc_q, desc_d;
  logic                  signed_q, signed_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [WCW-1:0]        wait_q, wait_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]  fail_q, fail_d;

  logic                  le_asc, le_desc, ordered;
  logic [CNT_WIDTH-1:0]  idx_inc;

  // Equal values satisfy both directions, so both tests are inclusive
  assign le_asc  = signed_q ? ($signed(prev_q) <= $signed(cur_q)) : (prev_q <= cur_q);
  assign le_desc = signed_q ? ($signed(cur_q) <= $signed(prev_q)) : (cur_q <= prev_q);
  assign ordered = desc_q ? le_desc : le_asc;
  assign idx_inc = idx_q + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      desc_q    <= 1'b0;
      signed_q  <= 1'b0;
      idx_q     <= '0;
      prev_q    <= '0;
      cur_q     <= '0;
      wait_q    <= '0;
      pass_q    <= 1'b1;
      timeout_q <= 1'b0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      desc_q    <= desc_d;
      signed_q  <= signed_d;
      idx_q     <= idx_d;
      prev_q    <= prev_d;
      cur_q     <= cur_d;
      wait_q    <= wait_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    desc_d    = desc_q;
    signed_d  = signed_q;
    idx_d     = idx_q;
    prev_d    = prev_q;
    cur_d     = cur_q;
    wait_d    = wait_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    fail_d    = fail_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = base_addr;
          count_d   = count;
          desc_d    = desc;
          signed_d  = is_signed;
          idx_d     = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          fail_d    = '0;
          if (count <= CNT_WIDTH'(1)) begin
            pass_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          // Element 0 only primes the comparison; no pair exists yet
          if (idx_q == '0) begin
            prev_d  = mem_rdata;
            idx_d   = CNT_WIDTH'(1);
            state_d = S_REQ;
          end else begin
            cur_d   = mem_rdata;
            state_d = S_CMP;
          end
        end else if (wait_q == WCW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          fail_d    = idx_q;
          state_d   = S_FIN;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_CMP: begin
        if (ordered) begin
          prev_d = cur_q;
          idx_d  = idx_inc;
          if (idx_inc == count_q) begin
            pass_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          fail_d  = idx_q - CNT_WIDTH'(1);
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_rd     = (state_q == S_REQ);
  assign mem_addr   = (state_q == S_REQ) ?
                      base_q + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(STRIDE) : '0;
  assign busy       = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_CMP);
  assign done       = (state_q == S_FIN);
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign fail_index = fail_q;

endmodule

// File: tb/tb_mem_order_checker.sv
// Directed bench for mem_order_checker with a 1-cycle memory model that can withhold
// the read strobe for one chosen address.
module tb_mem_order_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] count;
  logic        desc;
  logic        is_signed;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] fail_index;

  logic [31:0] mem      [0:255];
  logic [31:0] addr_log [0:255];
  int          rd_cnt = 0;
  int          rd_base;
  logic        hold_en;
  logic [31:0] hold_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  bit found;

  always #5 clk = ~clk;

  mem_order_checker #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .CNT_WIDTH (16),
    .STRIDE    (4),
    .TIMEOUT   (16)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .desc      (desc),
    .is_signed (is_signed),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .fail_index(fail_index)
  );

  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (mem_rd) begin
      addr_log[rd_cnt % 256] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
      if (!(hold_en && mem_addr == hold_addr)) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem[mem_addr[9:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Returns cyc = negedges after the start-sampling edge until done is seen (0 = never)
  task automatic run_scan(input logic [31:0] b, input logic [15:0] n, input logic d,
                          input logic s, input bit spam, output int c);
    @(negedge clk);
    base_addr = b; count = n; desc = d; is_signed = s; start = 1'b1;
    rd_base = rd_cnt;
    c = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        c = k;
        start = 1'b0;
        break;
      end
      start = spam;
      if (spam) begin
        base_addr = 32'h40; count = 16'd2; desc = ~desc; is_signed = ~is_signed;
      end
    end
    start = 1'b0;
    if (c == 0) check("done_never_seen", 32'd0, 32'd1);
  endtask

  task automatic load_ramp();
    for (int unsigned i = 0; i < 12; i++) mem[128 + i] = 11 * i;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; count = '0; desc = 1'b0; is_signed = 1'b0;
    hold_en = 1'b0; hold_addr = '0;
    for (int unsigned i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_pass", pass, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_fail_index", fail_index, 0);
    check("rst_mem_rd", mem_rd, 0);
    rst = 1'b1;

    // T1: ascending ramp, full pass
    load_ramp();
    run_scan(32'd512, 16'd12, 1'b0, 1'b0, 1'b0, cyc);
    check("t1_cycles", cyc, 36);
    check("t1_pass", pass, 1);
    check("t1_fail_index", fail_index, 0);
    check("t1_timeout", timeout, 0);
    check("t1_reads", rd_cnt - rd_base, 12);
    check("t1_busy_at_done", busy, 0);
    @(negedge clk);
    check("t1_done_one_cycle", done, 0);

    // T2: first bad pair is (88, 0) at index 1
    begin
      logic [31:0] v [0:11] = '{55, 88, 0, 22, 77, 11, 99, 33, 110, 66, 121, 44};
      for (int i = 0; i < 12; i++) mem[128 + i] = v[i];
    end
    run_scan(32'd512, 16'd12, 1'b0, 1'b0, 1'b0, cyc);
    check("t2_cycles", cyc, 9);
    check("t2_pass", pass, 0);
    check("t2_fail_index", fail_index, 1);
    check("t2_reads", rd_cnt - rd_base, 3);
    check("t2_addr0", addr_log[(rd_base + 0) % 256], 512);
    check("t2_addr1", addr_log[(rd_base + 1) % 256], 516);
    check("t2_addr2", addr_log[(rd_base + 2) % 256], 520);

    // T3: degenerate counts
    run_scan(32'd512, 16'd0, 1'b0, 1'b0, 1'b0, cyc);
    check("t3_c0_cycles", cyc, 1);
    check("t3_c0_pass", pass, 1);
    check("t3_c0_reads", rd_cnt - rd_base, 0);
    check("t3_c0_fail_index", fail_index, 0);
    run_scan(32'd512, 16'd1, 1'b0, 1'b0, 1'b0, cyc);
    check("t3_c1_cycles", cyc, 1);
    check("t3_c1_pass", pass, 1);
    check("t3_c1_reads", rd_cnt - rd_base, 0);

    // T4: 5,0,-3,-3,-7 descending; unsigned view breaks at (0, 0xFFFFFFFD)
    mem[64] = 32'd5; mem[65] = 32'd0; mem[66] = 32'hFFFF_FFFD;
    mem[67] = 32'hFFFF_FFFD; mem[68] = 32'hFFFF_FFF9;
    run_scan(32'd256, 16'd5, 1'b1, 1'b1, 1'b0, cyc);
    check("t4_signed_cycles", cyc, 15);
    check("t4_signed_pass", pass, 1);
    run_scan(32'd256, 16'd5, 1'b1, 1'b0, 1'b0, cyc);
    check("t4_unsigned_cycles", cyc, 9);
    check("t4_unsigned_pass", pass, 0);
    check("t4_unsigned_fail_index", fail_index, 1);

    // T5: read strobe withheld for idx 3 -> 16 WAIT cycles then FIN
    load_ramp();
    hold_en = 1'b1; hold_addr = 32'd524;
    run_scan(32'd512, 16'd6, 1'b0, 1'b0, 1'b0, cyc);
    check("t5_cycles", cyc, 26);
    check("t5_timeout", timeout, 1);
    check("t5_pass", pass, 0);
    check("t5_fail_index", fail_index, 3);
    check("t5_reads", rd_cnt - rd_base, 4);
    hold_en = 1'b0;

    // T6a: reset while in WAIT at idx 5
    hold_en = 1'b1; hold_addr = 32'd532;
    @(negedge clk);
    base_addr = 32'd512; count = 16'd12; desc = 1'b0; is_signed = 1'b0; start = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_rd && mem_addr == 32'd532) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reached_idx5", found, 1);
    check("t6_pass_cleared", pass, 0);
    check("t6_timeout_cleared", timeout, 0);
    @(negedge clk);
    check("t6_in_wait", busy, 1);
    rst = 1'b0;
    rd_base = rd_cnt;
    @(negedge clk);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_pass", pass, 1);
    check("t6_rst_mem_rd", mem_rd, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_reads_after_rst", rd_cnt - rd_base, 0);
    check("t6_idle_busy", busy, 0);
    check("t6_idle_done", done, 0);
    hold_en = 1'b0;

    // T6b: start/config toggling while busy must not disturb the scan
    run_scan(32'd512, 16'd12, 1'b0, 1'b0, 1'b1, cyc);
    check("t6b_cycles", cyc, 36);
    check("t6b_pass", pass, 1);
    check("t6b_reads", rd_cnt - rd_base, 12);
    for (int i = 0; i < 12; i++)
      check($sformatf("t6b_addr%0d", i), addr_log[(rd_base + i) % 256], 32'(512 + 4 * i));
    @(negedge clk);
    check("t6b_back_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
